// File: rtl/jedro_1_prefetch_ifu_pkg.sv
// Shared constants and types for the jedro_1 prefetching fetch unit.
// Also holds the FIFO entry layout, which the LSU can reuse.
package jedro_1_prefetch_ifu_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] BOOT_ADDR = 32'h0000_0000;

    localparam int unsigned IFU_FIFO_DEPTH  = 4;
    localparam int unsigned IFU_MEM_LATENCY = 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] instr;
    } ifu_entry_t;

    function automatic logic [DATA_WIDTH-1:0] word_align(input logic [DATA_WIDTH-1:0] a);
        return {a[DATA_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/jedro_1_prefetch_ifu_if.sv
// Single-port instruction memory bus: address out, read data back after the
// memory's fixed latency.
interface if_ram_1way;
    import jedro_1_prefetch_ifu_pkg::*;

    logic [DATA_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport MASTER (output ram_addr, input ram_rdata);
    modport SLAVE  (input ram_addr, output ram_rdata);

endinterface

// File: rtl/jedro_1_prefetch_ifu_sync_fifo.sv
// Generic synchronous FIFO with flush; DEPTH must be a power of two so the
// pointers wrap naturally.
module jedro_1_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = logic,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  T              din,
    output T              dout,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    T              mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO is fine then.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/jedro_1_prefetch_ifu.sv
// Pipelined sequential instruction fetch with a prefetch FIFO and jump flush.
// Fetches are credit-limited so every in-flight read has a guaranteed FIFO slot.
module jedro_1_prefetch_ifu #(
    parameter int unsigned MEM_LATENCY = jedro_1_prefetch_ifu_pkg::IFU_MEM_LATENCY,
    parameter int unsigned FIFO_DEPTH  = jedro_1_prefetch_ifu_pkg::IFU_FIFO_DEPTH,
    parameter logic [jedro_1_prefetch_ifu_pkg::DATA_WIDTH-1:0] BOOT_ADDR =
        jedro_1_prefetch_ifu_pkg::BOOT_ADDR
) (
    input  logic                                         clk_i,
    input  logic                                         rstn_i,
    input  logic                                         jmp_instr_i,
    input  logic [jedro_1_prefetch_ifu_pkg::DATA_WIDTH-1:0] jmp_address_i,
    output logic [jedro_1_prefetch_ifu_pkg::DATA_WIDTH-1:0] cinstr_o,
    output logic [jedro_1_prefetch_ifu_pkg::DATA_WIDTH-1:0] cinstr_addr_o,
    output logic                                         cinstr_valid_o,
    input  logic                                         cinstr_ready_i,
    if_ram_1way.MASTER                                   if_instr_mem
);
    import jedro_1_prefetch_ifu_pkg::*;

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0]                  fetch_pc_r;
    logic [MEM_LATENCY:1]                   vld_pipe;
    logic [MEM_LATENCY:1][DATA_WIDTH-1:0]   addr_pipe;
    logic                                   issue;

    ifu_entry_t    fifo_din;
    ifu_entry_t    fifo_dout;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;

    assign if_instr_mem.ram_addr = fetch_pc_r;

    assign cinstr_valid_o = ~fifo_empty;
    assign cinstr_o       = fifo_dout.instr;
    assign cinstr_addr_o  = fifo_dout.addr;

    assign fifo_pop  = cinstr_valid_o & cinstr_ready_i;
    assign fifo_push = vld_pipe[MEM_LATENCY] & ~jmp_instr_i;
    assign fifo_din  = '{addr: addr_pipe[MEM_LATENCY], instr: if_instr_mem.ram_rdata};

    // A pop this cycle returns its slot immediately; without that, sustained
    // 1/cycle would need a FIFO one entry deeper than MEM_LATENCY+1.
    always_comb begin
        issue = 1'b0;
        if (!jmp_instr_i &&
            (int'(fifo_count) + $countones(vld_pipe) - int'(fifo_pop) < int'(FIFO_DEPTH)))
            issue = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            fetch_pc_r <= BOOT_ADDR;
            vld_pipe   <= '0;
            addr_pipe  <= '0;
        end else if (jmp_instr_i) begin
            fetch_pc_r <= word_align(jmp_address_i);
            vld_pipe   <= '0;
        end else begin
            vld_pipe[1]  <= issue;
            addr_pipe[1] <= fetch_pc_r;
            for (int s = 2; s <= int'(MEM_LATENCY); s++) begin
                vld_pipe[s]  <= vld_pipe[s-1];
                addr_pipe[s] <= addr_pipe[s-1];
            end
            if (issue) fetch_pc_r <= fetch_pc_r + 32'd4;
            assert (!(fifo_push && fifo_full && !fifo_pop));
        end
    end

    jedro_1_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (ifu_entry_t)
    ) u_fifo (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .flush  (jmp_instr_i),
        .din    (fifo_din),
        .dout   (fifo_dout),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .count  (fifo_count)
    );

endmodule

// File: tb/tb_jedro_1_prefetch_ifu.sv
// Bench for the prefetch IFU: two instances (latency 1 and 3) against ROM
// models, with an in-order address-stream scoreboard per instance.
module tb_jedro_1_prefetch_ifu;

    localparam logic [31:0] A_BOOT = 32'h0000_0000;
    localparam logic [31:0] B_BOOT = 32'h0000_1000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        a_rstn, a_jmp, a_ready, a_valid;
    logic [31:0] a_jaddr, a_instr, a_addr;
    logic        b_rstn, b_jmp, b_ready, b_valid;
    logic [31:0] b_jaddr, b_instr, b_addr;

    logic [31:0] a_exp, b_exp;
    int          a_seen, b_seen;

    if_ram_1way ifa ();
    if_ram_1way ifb ();

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    logic [31:0] a_d1;
    logic [31:0] b_d [3];
    always @(posedge clk) begin
        a_d1   <= ifa.ram_addr;
        b_d[0] <= ifb.ram_addr;
        b_d[1] <= b_d[0];
        b_d[2] <= b_d[1];
    end
    assign ifa.ram_rdata = rom(a_d1);
    assign ifb.ram_rdata = rom(b_d[2]);

    jedro_1_prefetch_ifu #(.MEM_LATENCY(1), .FIFO_DEPTH(4), .BOOT_ADDR(A_BOOT)) u_a (
        .clk_i(clk), .rstn_i(a_rstn), .jmp_instr_i(a_jmp), .jmp_address_i(a_jaddr),
        .cinstr_o(a_instr), .cinstr_addr_o(a_addr), .cinstr_valid_o(a_valid),
        .cinstr_ready_i(a_ready), .if_instr_mem(ifa));

    jedro_1_prefetch_ifu #(.MEM_LATENCY(3), .FIFO_DEPTH(4), .BOOT_ADDR(B_BOOT)) u_b (
        .clk_i(clk), .rstn_i(b_rstn), .jmp_instr_i(b_jmp), .jmp_address_i(b_jaddr),
        .cinstr_o(b_instr), .cinstr_addr_o(b_addr), .cinstr_valid_o(b_valid),
        .cinstr_ready_i(b_ready), .if_instr_mem(ifb));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: score transfers of the current cycle, advance, then check
    // that valid only drops after a pop, jump or reset.
    task automatic step();
        logic pv_a, pp_a, pj_a, pr_a, pv_b, pp_b, pj_b, pr_b;
        logic [31:0] pad_a, pad_b;
        pv_a = a_valid; pp_a = a_valid && a_ready; pj_a = a_jmp; pr_a = a_rstn; pad_a = a_addr;
        pv_b = b_valid; pp_b = b_valid && b_ready; pj_b = b_jmp; pr_b = b_rstn; pad_b = b_addr;
        if (pr_a && pp_a) begin
            chk("a_addr", a_addr, a_exp);
            chk("a_instr", a_instr, rom(a_exp));
            a_exp += 32'd4; a_seen++;
        end
        if (pr_a && pj_a) a_exp = a_jaddr & ~32'h3;
        if (!pr_a) a_exp = A_BOOT;
        if (pr_b && pp_b) begin
            chk("b_addr", b_addr, b_exp);
            chk("b_instr", b_instr, rom(b_exp));
            b_exp += 32'd4; b_seen++;
        end
        if (pr_b && pj_b) b_exp = b_jaddr & ~32'h3;
        if (!pr_b) b_exp = B_BOOT;
        @(posedge clk); #1;
        if (pr_a && pj_a) chk("a_jmp_vld_low", a_valid, 0);
        else if (pr_a && pv_a && !pp_a) begin
            chk("a_hold_vld", a_valid, 1);
            chk("a_hold_addr", a_addr, pad_a);
        end
        if (pr_b && pj_b) chk("b_jmp_vld_low", b_valid, 0);
        else if (pr_b && pv_b && !pp_b) begin
            chk("b_hold_vld", b_valid, 1);
            chk("b_hold_addr", b_addr, pad_b);
        end
    endtask

    task automatic reset_a();
        a_rstn = 0; a_jmp = 0;
        step(); step();
        a_rstn = 1; a_seen = 0;
    endtask

    // From cycle 0 with ready high: boot address, 2-cycle first latency, no bubbles.
    task automatic boot_run_a();
        for (int c = 0; c < 12; c++) begin
            chk("a_ram_seq", ifa.ram_addr, A_BOOT + 32'(4 * c));
            chk("a_vld_seq", a_valid, c >= 2);
            step();
        end
        chk("a_boot_seen", a_seen, 10);
    endtask

    initial begin
        a_rstn = 0; a_jmp = 0; a_jaddr = '0; a_ready = 0;
        b_rstn = 0; b_jmp = 0; b_jaddr = '0; b_ready = 0;
        a_exp = A_BOOT; b_exp = B_BOOT; a_seen = 0; b_seen = 0;
        @(posedge clk); #1;

        // reset release, streaming
        a_ready = 1;
        reset_a();
        chk("a_rst_vld", a_valid, 0);
        chk("a_rst_instr", a_instr, 0);
        chk("a_rst_addr", a_addr, 0);
        boot_run_a();

        // back-pressure from cycle 0
        a_ready = 0;
        reset_a();
        for (int c = 0; c < 10; c++) begin
            chk("a_bp_ram", ifa.ram_addr, (c < 4) ? 32'(4 * c) : 32'h10);
            step();
        end
        chk("a_bp_vld", a_valid, 1);
        chk("a_bp_head", a_addr, 32'h0);
        a_ready = 1;
        for (int c = 0; c < 12; c++) begin
            chk("a_bp_drain_vld", a_valid, 1);
            step();
        end
        chk("a_bp_seen", a_seen, 12);

        // jump to 0x103 in cycle 5
        reset_a();
        repeat (5) step();
        chk("a_prejmp_head", a_addr, 32'hC);
        a_jmp = 1; a_jaddr = 32'h103;
        step();
        a_jmp = 0;
        chk("a_jmp_ram", ifa.ram_addr, 32'h100);
        step();
        chk("a_jmp_vld_c7", a_valid, 0);
        step();
        chk("a_jmp_vld_c8", a_valid, 1);
        chk("a_jmp_tgt", a_addr, 32'h100);
        repeat (4) step();

        // jump coincident with pop of 0x8
        reset_a();
        repeat (4) step();
        chk("a_pop8_head", a_addr, 32'h8);
        a_jmp = 1; a_jaddr = $urandom;
        step();
        a_jmp = 0;
        repeat (6) step();
        chk("a_pop8_seen", a_seen, 7);

        // random ready and jumps, including a wrap through 2^32
        for (int i = 0; i < 400; i++) begin
            a_ready = ($urandom_range(0, 3) != 0);
            a_jmp   = ($urandom_range(0, 24) == 0) || (i == 200);
            a_jaddr = (i == 200) ? 32'hFFFF_FFF9 : $urandom;
            if (i > 200 && i < 215) begin a_ready = 1; a_jmp = 0; end
            step();
        end
        a_jmp = 0;

        // reset mid-stream with a full FIFO plus an in-flight read
        a_ready = 0;
        reset_a();
        repeat (4) step();
        chk("a_mid_vld", a_valid, 1);
        a_rstn = 0;
        step();
        chk("a_mid_rst_vld", a_valid, 0);
        chk("a_mid_rst_ram", ifa.ram_addr, A_BOOT);
        chk("a_mid_rst_addr", a_addr, 0);
        chk("a_mid_rst_instr", a_instr, 0);
        step();
        a_rstn = 1; a_ready = 1; a_seen = 0;
        boot_run_a();
        a_rstn = 0;

        // latency-3 instance
        b_ready = 1;
        b_rstn = 0; step(); step(); b_rstn = 1; b_seen = 0;
        chk("b_rst_vld", b_valid, 0);
        chk("b_rst_ram", ifb.ram_addr, B_BOOT);
        for (int c = 0; c < 20; c++) begin
            chk("b_vld_seq", b_valid, c >= 4);
            chk("b_ram_seq", ifb.ram_addr, B_BOOT + 32'(4 * c));
            step();
        end
        chk("b_seen", b_seen, 16);
        b_jmp = 1; b_jaddr = 32'h2222_2222;
        step();
        b_jmp = 0;
        chk("b_jmp_ram", ifb.ram_addr, 32'h2222_2220);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("b_jmp_vld_low", b_valid, 0);
        end
        step();
        chk("b_jmp_vld", b_valid, 1);
        chk("b_jmp_tgt", b_addr, 32'h2222_2220);
        for (int i = 0; i < 300; i++) begin
            b_ready = ($urandom_range(0, 2) != 0);
            b_jmp   = ($urandom_range(0, 40) == 0);
            b_jaddr = $urandom;
            step();
        end
        b_jmp = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
